// File: rtl/feedback_scorer.sv
// Mastermind feedback stage: scores a committed guess against the secret code over
// a fixed 6-cycle sequence and keeps per-game turn, win and game-over state.
module feedback_scorer #(
    parameter int MAX_TURNS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       new_game,
    input  logic [2:0] guess0,
    input  logic [2:0] guess1,
    input  logic [2:0] guess2,
    input  logic [2:0] guess3,
    input  logic [2:0] code0,
    input  logic [2:0] code1,
    input  logic [2:0] code2,
    input  logic [2:0] code3,
    output logic       busy,
    output logic       done,
    output logic [1:0] ssd0,
    output logic [1:0] ssd1,
    output logic [1:0] ssd2,
    output logic [1:0] ssd3,
    output logic [2:0] exact_cnt,
    output logic [2:0] color_cnt,
    output logic [3:0] turn_cnt,
    output logic       win,
    output logic       game_over
);

    typedef enum logic [1:0] {IDLE, EXACT, COLOR, PACK} state_t;

    state_t     state_reg, state_next;
    logic [2:0] guess_in [4];
    logic [2:0] code_in  [4];
    logic [2:0] guess_reg [4];
    logic [2:0] code_reg  [4];
    logic [3:0] exact_flag_reg, code_used_reg;
    logic [1:0] idx_reg;
    logic [2:0] exact_acc_reg, color_acc_reg;

    logic [3:0] exact_hit, color_cand, color_pick;
    logic       color_found;
    logic [2:0] exact_pop, match_total;
    logic [1:0] ssd_next [4];
    logic [3:0] turn_next;
    logic       win_next, accept;

    assign guess_in[0] = guess0;
    assign guess_in[1] = guess1;
    assign guess_in[2] = guess2;
    assign guess_in[3] = guess3;
    assign code_in[0]  = code0;
    assign code_in[1]  = code1;
    assign code_in[2]  = code2;
    assign code_in[3]  = code3;

    assign accept = (state_reg == IDLE) && start && !game_over && !new_game;

    assign match_total = exact_acc_reg + color_acc_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pos
            assign exact_hit[gi]  = (guess_reg[gi] == code_reg[gi]);
            // Candidate code slots for the guess position currently being searched.
            assign color_cand[gi] = !code_used_reg[gi] && (code_reg[gi] == guess_reg[idx_reg]);
            assign ssd_next[gi]   = (3'(gi) < exact_acc_reg) ? 2'd2 :
                                    (3'(gi) < match_total)   ? 2'd1 : 2'd0;
        end
    endgenerate

    assign exact_pop = {2'b00, exact_hit[0]} + {2'b00, exact_hit[1]}
                     + {2'b00, exact_hit[2]} + {2'b00, exact_hit[3]};

    // Lowest unused matching code slot; positions already scored exact never search.
    always_comb begin
        color_pick  = 4'b0000;
        color_found = 1'b0;
        if (!exact_flag_reg[idx_reg]) begin
            for (int j = 0; j < 4; j++) begin
                if (color_cand[j] && !color_found) begin
                    color_pick[j] = 1'b1;
                    color_found   = 1'b1;
                end
            end
        end
    end

    assign turn_next = (turn_cnt == 4'd15) ? 4'd15 : turn_cnt + 4'd1;
    assign win_next  = (exact_acc_reg == 3'd4);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (new_game) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (accept) state_next = EXACT;
                EXACT:   state_next = COLOR;
                COLOR:   if (idx_reg == 2'd3) state_next = PACK;
                PACK:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_reg != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                guess_reg[k] <= 3'd0;
                code_reg[k]  <= 3'd0;
            end
            exact_flag_reg <= 4'd0;
            code_used_reg  <= 4'd0;
            idx_reg        <= 2'd0;
            exact_acc_reg  <= 3'd0;
            color_acc_reg  <= 3'd0;
            done           <= 1'b0;
            ssd0           <= 2'd0;
            ssd1           <= 2'd0;
            ssd2           <= 2'd0;
            ssd3           <= 2'd0;
            exact_cnt      <= 3'd0;
            color_cnt      <= 3'd0;
            turn_cnt       <= 4'd0;
            win            <= 1'b0;
            game_over      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (new_game) begin
                exact_flag_reg <= 4'd0;
                code_used_reg  <= 4'd0;
                idx_reg        <= 2'd0;
                exact_acc_reg  <= 3'd0;
                color_acc_reg  <= 3'd0;
                ssd0           <= 2'd0;
                ssd1           <= 2'd0;
                ssd2           <= 2'd0;
                ssd3           <= 2'd0;
                exact_cnt      <= 3'd0;
                color_cnt      <= 3'd0;
                turn_cnt       <= 4'd0;
                win            <= 1'b0;
                game_over      <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (accept) begin
                            for (int k = 0; k < 4; k++) begin
                                guess_reg[k] <= guess_in[k];
                                code_reg[k]  <= code_in[k];
                            end
                            exact_flag_reg <= 4'd0;
                            code_used_reg  <= 4'd0;
                            exact_acc_reg  <= 3'd0;
                            color_acc_reg  <= 3'd0;
                        end
                    end
                    EXACT: begin
                        exact_flag_reg <= exact_hit;
                        code_used_reg  <= exact_hit;
                        exact_acc_reg  <= exact_pop;
                        color_acc_reg  <= 3'd0;
                        idx_reg        <= 2'd0;
                    end
                    COLOR: begin
                        code_used_reg <= code_used_reg | color_pick;
                        if (color_found) color_acc_reg <= color_acc_reg + 3'd1;
                        idx_reg <= idx_reg + 2'd1;
                    end
                    PACK: begin
                        exact_cnt <= exact_acc_reg;
                        color_cnt <= color_acc_reg;
                        ssd0      <= ssd_next[0];
                        ssd1      <= ssd_next[1];
                        ssd2      <= ssd_next[2];
                        ssd3      <= ssd_next[3];
                        turn_cnt  <= turn_next;
                        win       <= win_next;
                        game_over <= win_next || (turn_next == 4'(MAX_TURNS));
                        done      <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_feedback_scorer.sv
// Directed bench for feedback_scorer: hand-computed scoring vectors, turn limit,
// new_game/start interaction and asynchronous reset in the middle of a search.
module tb_feedback_scorer;

    logic       clk = 1'b0;
    logic       reset, start, new_game;
    logic [2:0] guess0, guess1, guess2, guess3;
    logic [2:0] code0, code1, code2, code3;
    logic       busy, done, win, game_over;
    logic [1:0] ssd0, ssd1, ssd2, ssd3;
    logic [2:0] exact_cnt, color_cnt;
    logic [3:0] turn_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    feedback_scorer #(.MAX_TURNS(8)) dut (
        .clk(clk), .reset(reset), .start(start), .new_game(new_game),
        .guess0(guess0), .guess1(guess1), .guess2(guess2), .guess3(guess3),
        .code0(code0), .code1(code1), .code2(code2), .code3(code3),
        .busy(busy), .done(done),
        .ssd0(ssd0), .ssd1(ssd1), .ssd2(ssd2), .ssd3(ssd3),
        .exact_cnt(exact_cnt), .color_cnt(color_cnt), .turn_cnt(turn_cnt),
        .win(win), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e, input int c,
                           input int s0, input int s1, input int s2, input int s3,
                           input int w, input int go, input int t);
        chk({tag, ".exact"},     32'(exact_cnt), 32'(e));
        chk({tag, ".color"},     32'(color_cnt), 32'(c));
        chk({tag, ".ssd0"},      32'(ssd0),      32'(s0));
        chk({tag, ".ssd1"},      32'(ssd1),      32'(s1));
        chk({tag, ".ssd2"},      32'(ssd2),      32'(s2));
        chk({tag, ".ssd3"},      32'(ssd3),      32'(s3));
        chk({tag, ".win"},       32'(win),       32'(w));
        chk({tag, ".game_over"}, 32'(game_over), 32'(go));
        chk({tag, ".turn"},      32'(turn_cnt),  32'(t));
    endtask

    task automatic set_vec(input logic [2:0] c0, input logic [2:0] c1, input logic [2:0] c2,
                           input logic [2:0] c3, input logic [2:0] g0, input logic [2:0] g1,
                           input logic [2:0] g2, input logic [2:0] g3);
        code0 = c0; code1 = c1; code2 = c2; code3 = c3;
        guess0 = g0; guess1 = g1; guess2 = g2; guess3 = g3;
    endtask

    // Called at a negedge; returns at the negedge where done is seen (or after the budget).
    task automatic score(input string tag, input logic [2:0] c0, input logic [2:0] c1,
                         input logic [2:0] c2, input logic [2:0] c3, input logic [2:0] g0,
                         input logic [2:0] g1, input logic [2:0] g2, input logic [2:0] g3);
        int  lat;
        bit  got;
        set_vec(c0, c1, c2, c3, g0, g1, g2, g3);
        start = 1'b1;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (lat == 1) chk({tag, ".busy_after_start"}, 32'(busy), 32'd1);
            if (done) got = 1'b1;
        end
        chk({tag, ".latency"}, got ? 32'(lat - 1) : 32'd99, 32'd6);
        $display("txn %s: code %0d%0d%0d%0d guess %0d%0d%0d%0d -> exact=%0d color=%0d ssd=%0d%0d%0d%0d turn=%0d win=%0d go=%0d",
                 tag, c0, c1, c2, c3, g0, g1, g2, g3, exact_cnt, color_cnt,
                 ssd0, ssd1, ssd2, ssd3, turn_cnt, win, game_over);
    endtask

    task automatic done_pulse_ends(input string tag);
        @(negedge clk);
        chk({tag, ".done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, ".busy_cleared"},   32'(busy), 32'd0);
    endtask

    task automatic quiet_window(input string tag, input int n);
        int nb, nd;
        nb = 0;
        nd = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) nb++;
            if (done) nd++;
        end
        chk({tag, ".busy_cycles"}, 32'(nb), 32'd0);
        chk({tag, ".done_cycles"}, 32'(nd), 32'd0);
    endtask

    task automatic pulse_new_game(input string tag);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk_all(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("txn %s: new_game", tag);
    endtask

    initial begin
        int nd;
        reset = 1'b0;
        start = 1'b0;
        new_game = 1'b0;
        set_vec(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clk);

        // Winning guess, then a further start must be ignored.
        score("win", 1, 2, 3, 4, 1, 2, 3, 4);
        chk_all("win", 4, 0, 2, 2, 2, 2, 1, 1, 1);
        done_pulse_ends("win");
        start = 1'b1;
        quiet_window("start_after_win", 10);
        chk("start_after_win.turn", 32'(turn_cnt), 32'd1);

        pulse_new_game("ng1");
        score("permute", 1, 2, 3, 4, 4, 3, 2, 1);
        chk_all("permute", 0, 4, 1, 1, 1, 1, 0, 0, 1);
        done_pulse_ends("permute");

        score("dup_a", 1, 2, 1, 5, 2, 1, 1, 1);
        chk_all("dup_a", 1, 2, 2, 1, 1, 0, 0, 0, 2);

        score("dup_b", 1, 1, 2, 3, 1, 1, 1, 1);
        chk_all("dup_b", 2, 0, 2, 2, 0, 0, 0, 0, 3);

        // Start while busy: exactly one done and one turn.
        pulse_new_game("ng2");
        set_vec(0, 0, 0, 0, 7, 7, 7, 7);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("start_busy.done_count", 32'(nd), 32'd1);
        chk_all("start_busy", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        $display("txn start_busy: dones=%0d turn=%0d", nd, turn_cnt);

        // Turns 2..8 of the same losing game.
        for (int t = 2; t <= 8; t++) begin
            score("turns", 0, 0, 0, 0, 7, 7, 7, 7);
            chk("turns.turn", 32'(turn_cnt), 32'(t));
            chk("turns.game_over", 32'(game_over), (t == 8) ? 32'd1 : 32'd0);
        end
        chk_all("max_turns", 0, 0, 0, 0, 0, 0, 0, 1, 8);
        start = 1'b1;
        quiet_window("ninth_start", 10);
        chk("ninth_start.turn", 32'(turn_cnt), 32'd8);

        pulse_new_game("ng3");
        score("after_ng", 1, 2, 3, 4, 1, 2, 5, 6);
        chk_all("after_ng", 2, 0, 2, 2, 0, 0, 0, 0, 1);

        // Asynchronous reset in the middle of the colour search.
        @(negedge clk);
        set_vec(1, 2, 3, 4, 4, 3, 2, 1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("async_rst.busy", 32'(busy), 32'd0);
        chk("async_rst.done", 32'(done), 32'd0);
        chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("txn async_rst: reset asserted mid-search");
        quiet_window("async_rst_hold", 10);
        reset = 1'b1;
        quiet_window("async_rst_after", 8);

        // new_game together with start: new_game wins.
        score("pre_ng_start", 1, 2, 3, 4, 4, 3, 2, 1);
        chk("pre_ng_start.turn", 32'(turn_cnt), 32'd1);
        @(negedge clk);
        new_game = 1'b1;
        start = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        start = 1'b0;
        chk("ng_start.busy", 32'(busy), 32'd0);
        chk_all("ng_start", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("txn ng_start: new_game with start");
        quiet_window("ng_start_after", 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/feedback_scorer.md
# feedback_scorer

Sequential Mastermind scoring stage between the guess history and the seven-segment converters. On each committed guess it compares the four 3-bit guess colours with the four 3-bit secret code colours. It counts exact (position and colour) and colour-only matches, honouring duplicates. It then emits four 2-bit feedback digits for the SSD converters, and tracks turn count, win and game-over for the rest of the game.

## Interface
Parameters:
- MAX_TURNS, 8, number of guesses allowed per game; legal range 1..15.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: score the current guess; sampled only in IDLE.
- new_game  in  1  one-cycle pulse: clear turn/win/game_over/feedback.
- guess0..guess3  in  3 each  committed guess colours, position 0..3.
- code0..code3  in  3 each  secret code colours, position 0..3.
- busy  out  1  high while scoring is in progress.
- done  out  1  one-cycle pulse when new results are valid.
- ssd0..ssd3  out  2 each  feedback digits: 2'd2 exact, 2'd1 colour-only, 2'd0 blank; 2'd3 never driven.
- exact_cnt  out  3  exact matches of the last scored guess (0..4).
- color_cnt  out  3  colour-only matches of the last scored guess (0..4).
- turn_cnt  out  4  guesses scored this game.
- win  out  1  last scored guess had exact_cnt == 4.
- game_over  out  1  win, or turn_cnt == MAX_TURNS.

## Operation
- Reset (reset low, asynchronous): every output is 0, state is IDLE, and internal snapshots and used flags are cleared.
- States: IDLE, EXACT, COLOR, PACK.
- IDLE:
  - If start is high, game_over is low and new_game is low, snapshot guess0..3 and code0..3 into internal registers, set busy, and go to EXACT.
  - Inputs may change freely after the snapshot.
- EXACT (1 cycle):
  - For each position p, when guess[p] == code[p], set exact_flag[p] and code_used[p].
  - exact count = popcount(exact_flag).
  - Go to COLOR with index i = 0.
- COLOR (4 cycles, i = 0..3):
  - If exact_flag[i] is clear, search code positions j = 0..3 for the lowest j with code_used[j] clear and code[j] == guess[i].
  - If found, set code_used[j] and increment the colour count. At most one code position is consumed per i.
  - After i = 3, go to PACK.
- PACK (1 cycle):
  - Register exact_cnt and color_cnt.
  - ssd[k] = 2'd2 if k < exact_cnt; 2'd1 if exact_cnt <= k < exact_cnt + color_cnt; else 2'd0.
  - turn_cnt += 1 (saturates at 15).
  - win = (exact_cnt == 4).
  - game_over = win or (turn_cnt_new == MAX_TURNS).
  - Pulse done, clear busy, return to IDLE.
- exact_cnt + color_cnt <= 4 always.
- Outputs hold their values until the next PACK, new_game, or reset.
- new_game in any state forces: IDLE; busy, done, win, game_over = 0; turn_cnt = 0; ssd0..3, exact_cnt, color_cnt = 0. Any scoring in progress is aborted, with no done and no turn increment.
- new_game and start in the same cycle: new_game wins; start is dropped.
- start while busy, or while game_over is high, is ignored (no queueing).

## Timing
- start sampled at edge N: busy high after edge N; EXACT occupies N..N+1; COLOR occupies edges N+2..N+5; PACK at edge N+6.
- After edge N+6: results valid, done = 1 for exactly one cycle, busy = 0.
- Fixed latency is 6 cycles from start to done; throughput is at most one guess per 7 cycles.
- A start sampled in the cycle done is high is accepted, because state is IDLE.
- new_game takes effect at the next edge. Reset takes effect immediately and asynchronously, including mid-COLOR.

## Test plan
- Code 1,2,3,4; guess 1,2,3,4; start.
  - done exactly 6 cycles later; exact_cnt = 4, color_cnt = 0.
  - ssd0..3 = 2,2,2,2; win = 1, game_over = 1, turn_cnt = 1.
  - A further start is ignored.
- Code 1,2,3,4; guess 4,3,2,1.
  - exact_cnt = 0, color_cnt = 4; ssd0..3 = 1,1,1,1; win = 0.
- Duplicates: code 1,2,1,5; guess 2,1,1,1.
  - exact_cnt = 1, color_cnt = 2; ssd0..3 = 2,1,1,0.
- Duplicates: code 1,1,2,3; guess 1,1,1,1.
  - exact_cnt = 2, color_cnt = 0; ssd0..3 = 2,2,0,0.
- MAX_TURNS = 8; eight non-winning guesses with code 0,0,0,0 and guess 7,7,7,7.
  - After the 8th done: turn_cnt = 8, game_over = 1, win = 0.
  - A 9th start gives no busy and no done.
  - new_game then clears all outputs to 0 and the next start is accepted.
- Robustness cases:
  - start during busy is ignored: only one done, turn_cnt += 1.
  - reset low at edge N+3 gives all outputs 0 immediately and no done.
  - new_game with simultaneous start gives state IDLE and no busy.
